// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the instruction assembler: immediate formats,
// opcode constants, the loader FSM states and the instruction field bundle.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    // Immediate format select, matches the core's ImmSrc decode
    typedef enum logic [1:0] {
        IMM_I   = 2'b00,
        IMM_S   = 2'b01,
        IMM_B   = 2'b10,
        IMM_RAW = 2'b11
    } imm_src_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Program-loader session states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10,
        ST_FULL = 2'b11
    } asm_state_e;

    // Register and function fields of one instruction
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } instr_fields_t;

endpackage : rv32i_pkg

// File: rtl/imm_pack.sv
// Combinational immediate scatter: builds an RV32I word from fields and a
// sign-extended immediate, flagging immediates that do not fit the format.
// Ports:
//   imm_src   - format select (I/S/B/raw)
//   imm       - sign-extended 32-bit immediate
//   fields    - opcode/funct3/rd/rs1/rs2
//   raw       - full word used for the raw format
//   word      - assembled instruction word
//   range_err - immediate out of range (immediate bits forced to zero)
module imm_pack
    import rv32i_pkg::*;
(
    input  imm_src_e      imm_src,
    input  logic [31:0]   imm,
    input  instr_fields_t fields,
    input  logic [31:0]   raw,
    output logic [31:0]   word,
    output logic          range_err
);

    logic        fits12;
    logic        fits13;
    logic [31:0] imm_v;

    // Upper bits must all replicate the sign bit of the encoded field
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        imm_v     = imm;
        unique case (imm_src)
            IMM_I: begin
                range_err = ~fits12;
                imm_v     = range_err ? 32'd0 : imm;
                word      = {imm_v[11:0], fields.rs1, fields.funct3,
                             fields.rd, fields.opcode};
            end
            IMM_S: begin
                range_err = ~fits12;
                imm_v     = range_err ? 32'd0 : imm;
                word      = {imm_v[11:5], fields.rs2, fields.rs1,
                             fields.funct3, imm_v[4:0], fields.opcode};
            end
            IMM_B: begin
                // Branch offsets are halfword aligned; bit 0 is not encoded
                range_err = ~fits13 | imm[0];
                imm_v     = range_err ? 32'd0 : imm;
                word      = {imm_v[12], imm_v[10:5], fields.rs2, fields.rs1,
                             fields.funct3, imm_v[4:1], imm_v[11], fields.opcode};
            end
            default: begin
                word = raw;
            end
        endcase
    end

endmodule : imm_pack

// File: rtl/instr_assembler.sv
// Streaming instruction encoder and program loader. Accepts field bundles
// over valid/ready, assembles each into an RV32I word and writes the words
// to sequential instruction-memory addresses one cycle after acceptance.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   start                 - opens a load session, clears address/status
//   in_valid/in_ready     - bundle handshake; in_last marks final word
//   ImmSrc, Imm, Opcode, Funct3, Rd, Rs1, Rs2, Raw - bundle contents
//   mem_we/addr/wdata     - instruction-memory write port
//   busy, done, full      - session status
//   imm_err, err_addr     - sticky range error and first failing address
//   count                 - words written in the current session
module instr_assembler
    import rv32i_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 64,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        ImmSrc,
    input  logic [31:0]       Imm,
    input  logic [6:0]        Opcode,
    input  logic [2:0]        Funct3,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Rs1,
    input  logic [4:0]        Rs2,
    input  logic [31:0]       Raw,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              imm_err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MEM_DEPTH);

    asm_state_e        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              wlast_q, wlast_d;
    logic              last_pend_q, last_pend_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              imm_err_q, imm_err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              full_q, full_d;

    instr_fields_t     fields;
    logic [31:0]       pack_word;
    logic              pack_err;
    logic              accept;

    assign fields = '{opcode: Opcode, funct3: Funct3, rd: Rd, rs1: Rs1, rs2: Rs2};

    imm_pack u_imm_pack (
        .imm_src   (imm_src_e'(ImmSrc)),
        .imm       (Imm),
        .fields    (fields),
        .raw       (Raw),
        .word      (pack_word),
        .range_err (pack_err)
    );

    // start wins over a same-cycle bundle
    assign accept = in_valid & in_ready_q & ~start;

    // Next-state, address/count bookkeeping and registered outputs
    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wlast_d     = 1'b0;
        last_pend_d = last_pend_q;
        acc_d       = acc_q;
        count_d     = count_q;
        imm_err_d   = imm_err_q;
        err_addr_d  = err_addr_q;

        if (start) begin
            state_d     = ST_LOAD;
            mem_addr_d  = '0;
            last_pend_d = 1'b0;
            acc_d       = '0;
            count_d     = '0;
            imm_err_d   = 1'b0;
            err_addr_d  = '0;
        end else begin
            // Session status follows completed writes
            if (mem_we_q) begin
                count_d = count_q + CNT_W'(1);
                if (state_q == ST_LOAD) begin
                    if (wlast_q) begin
                        state_d = ST_DONE;
                    end else if (count_q + CNT_W'(1) == DEPTH_C) begin
                        state_d = ST_FULL;
                    end
                end
            end
            if (accept) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = acc_q[ADDR_W-1:0];
                mem_wdata_d = pack_word;
                wlast_d     = in_last;
                last_pend_d = in_last;
                acc_d       = acc_q + CNT_W'(1);
                if (pack_err) begin
                    imm_err_d = 1'b1;
                    if (!imm_err_q) begin
                        err_addr_d = acc_q[ADDR_W-1:0];
                    end
                end
            end
        end

        in_ready_d = (state_d == ST_LOAD) && !last_pend_d && (acc_d < DEPTH_C);
        busy_d     = (state_d == ST_LOAD) || mem_we_d;
        done_d     = (state_d == ST_DONE);
        full_d     = (state_d == ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wlast_q     <= 1'b0;
            last_pend_q <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            imm_err_q   <= 1'b0;
            err_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wlast_q     <= wlast_d;
            last_pend_q <= last_pend_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            imm_err_q   <= imm_err_d;
            err_addr_q  <= err_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            full_q      <= full_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign full      = full_q;
    assign imm_err   = imm_err_q;
    assign err_addr  = err_addr_q;
    assign count     = count_q;

endmodule : instr_assembler

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler with a 4-word memory.
module tb_instr_assembler;

    localparam int unsigned MEM_DEPTH = 4;
    localparam int unsigned ADDR_W    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [1:0]        ImmSrc;
    logic [31:0]       Imm;
    logic [6:0]        Opcode;
    logic [2:0]        Funct3;
    logic [4:0]        Rd, Rs1, Rs2;
    logic [31:0]       Raw;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy, done, full, imm_err;
    logic [ADDR_W-1:0] err_addr;
    logic [ADDR_W:0]   count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_assembler #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .ImmSrc(ImmSrc), .Imm(Imm),
        .Opcode(Opcode), .Funct3(Funct3), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
        .Raw(Raw), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .full(full), .imm_err(imm_err),
        .err_addr(err_addr), .count(count)
    );

    // Stimulus drivers (called just after a falling edge)
    task automatic put(input logic [1:0] src, input logic [31:0] imm,
                       input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] raw,
                       input logic last);
        in_valid = 1'b1; ImmSrc = src; Imm = imm; Opcode = op; Funct3 = f3;
        Rd = rd; Rs1 = rs1; Rs2 = rs2; Raw = raw; in_last = last;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        ImmSrc = 2'b00; Imm = '0; Opcode = '0; Funct3 = '0;
        Rd = '0; Rs1 = '0; Rs2 = '0; Raw = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({mem_we, in_ready, busy, done, full, imm_err} !== 6'b0) begin n_err++; $display("FAIL reset_flags got=%b exp=000000", {mem_we, in_ready, busy, done, full, imm_err}); end
        n_cmp++; if ({mem_addr, mem_wdata, err_addr, count} !== '0) begin n_err++; $display("FAIL reset_values addr=%0d data=%h err_addr=%0d count=%0d exp all 0", mem_addr, mem_wdata, err_addr, count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_i_type();
        pulse_start();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL i_ready_after_start got=%b exp=1", in_ready); end
        put(2'b00, 32'd5, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd0) begin n_err++; $display("FAIL i_write we=%b addr=%0d exp we=1 addr=0", mem_we, mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h00500093) begin n_err++; $display("FAIL i_data got=%h exp=00500093", mem_wdata); end
        n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL i_last_ready ready=%b busy=%b exp ready=0 busy=1", in_ready, busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || count !== 3'd1 || mem_we !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL i_done done=%b count=%0d we=%b busy=%b exp 1/1/0/0", done, count, mem_we, busy); end
    endtask

    task automatic test_s_type();
        pulse_start();
        n_cmp++; if (done !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL s_start_clear done=%b count=%0d exp 0/0", done, count); end
        put(2'b01, 32'd8, 7'b0100011, 3'b010, 5'd0, 5'd3, 5'd2, 32'd0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (mem_wdata !== 32'h0021A423 || mem_addr !== 2'd0 || imm_err !== 1'b0) begin n_err++; $display("FAIL s_data got=%h addr=%0d err=%b exp 0021a423/0/0", mem_wdata, mem_addr, imm_err); end
        @(negedge clk);
    endtask

    task automatic test_b_type();
        pulse_start();
        put(2'b10, 32'hFFFFFFFC, 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (mem_wdata !== 32'hFE000EE3 || mem_addr !== 2'd0 || imm_err !== 1'b0) begin n_err++; $display("FAIL b_neg4 got=%h addr=%0d err=%b exp fe000ee3/0/0", mem_wdata, mem_addr, imm_err); end
        put(2'b10, 32'd3, 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== 32'h00000063) begin n_err++; $display("FAIL b_odd we=%b addr=%0d data=%h exp 1/1/00000063", mem_we, mem_addr, mem_wdata); end
        n_cmp++; if (imm_err !== 1'b1 || err_addr !== 2'd1) begin n_err++; $display("FAIL b_err err=%b err_addr=%0d exp 1/1", imm_err, err_addr); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || count !== 3'd2 || imm_err !== 1'b1) begin n_err++; $display("FAIL b_done done=%b count=%0d err=%b exp 1/2/1", done, count, imm_err); end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        n_cmp++; if (imm_err !== 1'b0 || err_addr !== 2'd0) begin n_err++; $display("FAIL btb_clear err=%b err_addr=%0d exp 0/0", imm_err, err_addr); end
        put(2'b00, 32'd1, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h00100093) begin n_err++; $display("FAIL btb_w0 we=%b addr=%0d data=%h exp 1/0/00100093", mem_we, mem_addr, mem_wdata); end
        put(2'b00, 32'd2048, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== 32'h00000093) begin n_err++; $display("FAIL btb_w1 we=%b addr=%0d data=%h exp 1/1/00000093", mem_we, mem_addr, mem_wdata); end
        n_cmp++; if (imm_err !== 1'b1 || err_addr !== 2'd1) begin n_err++; $display("FAIL btb_err1 err=%b err_addr=%0d exp 1/1", imm_err, err_addr); end
        put(2'b00, 32'hFFFFF7FF, 7'b0010011, 3'b000, 5'd2, 5'd1, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd2 || mem_wdata !== 32'h00008113) begin n_err++; $display("FAIL btb_w2 we=%b addr=%0d data=%h exp 1/2/00008113", mem_we, mem_addr, mem_wdata); end
        n_cmp++; if (imm_err !== 1'b1 || err_addr !== 2'd1) begin n_err++; $display("FAIL btb_err_sticky err=%b err_addr=%0d exp 1/1", imm_err, err_addr); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || count !== 3'd3) begin n_err++; $display("FAIL btb_done done=%b count=%0d exp 1/3", done, count); end
    endtask

    task automatic test_full();
        int b = 0;
        int n_acc = 0;
        int n_wr = 0;
        logic will_acc;
        pulse_start();
        put(2'b11, 32'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'h1000, 1'b0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            will_acc = in_ready & in_valid;
            @(negedge clk);
            if (mem_we === 1'b1) begin
                n_cmp++; if (mem_addr !== ADDR_W'(n_wr) || mem_wdata !== 32'h1000 + 32'(n_wr)) begin n_err++; $display("FAIL full_write%0d addr=%0d data=%h exp %0d/%h", n_wr, mem_addr, mem_wdata, n_wr, 32'h1000 + 32'(n_wr)); end
                n_wr++;
            end
            if (will_acc) begin
                n_acc++;
                if (b < 5) b++;
                Raw = 32'h1000 + 32'(b);
            end
        end
        n_cmp++; if (n_acc !== 4 || n_wr !== 4) begin n_err++; $display("FAIL full_counts accepts=%0d writes=%0d exp 4/4", n_acc, n_wr); end
        n_cmp++; if (full !== 1'b1 || count !== 3'd4 || in_ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL full_state full=%b count=%0d ready=%b busy=%b exp 1/4/0/0", full, count, in_ready, busy); end
        repeat (2) begin
            @(negedge clk);
            n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL full_ignore we=%b exp 0", mem_we); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse_start();
        put(2'b00, 32'd5, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || full !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_mid_flags we=%b ready=%b busy=%b full=%b done=%b exp all 0", mem_we, in_ready, busy, full, done); end
        n_cmp++; if (mem_addr !== 2'd0 || mem_wdata !== 32'd0 || count !== 3'd0 || imm_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_values addr=%0d data=%h count=%0d err=%b exp 0", mem_addr, mem_wdata, count, imm_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_idle ready=%b busy=%b exp 0/0", in_ready, busy); end
        pulse_start();
        put(2'b00, 32'd5, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h00500093) begin n_err++; $display("FAIL rst_resume we=%b addr=%0d data=%h exp 1/0/00500093", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_s_type();
        test_b_type();
        test_back_to_back();
        test_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_instr_assembler
